alu_fu_buffered: RTL

- Next-generation integer ALU functional unit for the out-of-order core. Sits between the ALU reservation station and the CDB arbiter.
- Fixed-latency pipeline of PIPE_STAGES register stages, followed by a BUF_DEPTH-entry in-order result FIFO. Results can wait for a CDB grant without stalling issue.
- Credit-based issue handshake, widened op set (compares and branch conditions), optional branch-tag squash.

---
 rtl/alu_fu_buffered.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_fu_buffered.sv
// -----------------------------------------------------------------------------
// alu_fu_buffered
//
// Integer ALU functional unit sitting between the ALU reservation station and
// the CDB arbiter. Ops are accepted under a credit scheme, computed in the
// first of PIPE_STAGES register stages, carried through the remaining stages
// and then written into a BUF_DEPTH-entry in-order result FIFO. The FIFO lets
// finished results wait for a CDB grant without blocking new issue.
//
// Optional feature macro: ALU_FU_BR_KILL_EN
//   When defined, the kill/clr ports exist and ops carrying a mispredicted
//   branch tag are squashed from both the pipeline and the FIFO, with the FIFO
//   compacting around the holes. When undefined, tags pass through untouched.
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_issue_valid  reservation station presents an op
//   o_issue_ready  unit has a free credit this cycle
//   i_issue_op     operation code (0 add .. 13 geu, 14-15 reserved -> 0)
//   i_issue_a/b    operands
//   i_issue_rob    destination ROB index
//   i_issue_tag    branch-tag mask of the op
//   o_res_valid    FIFO head holds a result
//   i_res_taken    CDB grant, pops the head when o_res_valid is high
//   o_res_data     head result (0 when empty)
//   o_res_rob      head ROB index (0 when empty)
//   o_res_tag      head branch-tag mask (0 when empty)
//   i_kill_valid   squash request                    (ALU_FU_BR_KILL_EN only)
//   i_kill_mask    mispredicted branch bits          (ALU_FU_BR_KILL_EN only)
//   i_clr_valid    branch resolved correctly         (ALU_FU_BR_KILL_EN only)
//   i_clr_mask     bits to clear from stored tags    (ALU_FU_BR_KILL_EN only)
// -----------------------------------------------------------------------------
module alu_fu_buffered #(
    parameter int XLEN        = 32,
    parameter int ROB_IDX_W   = 6,
    parameter int BR_TAG_W    = 4,
    parameter int PIPE_STAGES = 1,
    parameter int BUF_DEPTH   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_issue_valid,
    output logic                 o_issue_ready,
    input  logic [3:0]           i_issue_op,
    input  logic [XLEN-1:0]      i_issue_a,
    input  logic [XLEN-1:0]      i_issue_b,
    input  logic [ROB_IDX_W-1:0] i_issue_rob,
    input  logic [BR_TAG_W-1:0]  i_issue_tag,
    output logic                 o_res_valid,
    input  logic                 i_res_taken,
    output logic [XLEN-1:0]      o_res_data,
    output logic [ROB_IDX_W-1:0] o_res_rob,
    output logic [BR_TAG_W-1:0]  o_res_tag
`ifdef ALU_FU_BR_KILL_EN
    ,
    input  logic                 i_kill_valid,
    input  logic [BR_TAG_W-1:0]  i_kill_mask,
    input  logic                 i_clr_valid,
    input  logic [BR_TAG_W-1:0]  i_clr_mask
`endif
);

    localparam int SH_W  = $clog2(XLEN);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W = $clog2(BUF_DEPTH + PIPE_STAGES + 1);
    localparam int LAST  = PIPE_STAGES - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9,
        OP_EQ   = 4'd10,
        OP_NE   = 4'd11,
        OP_GE   = 4'd12,
        OP_GEU  = 4'd13
    } aluOp_e;

    typedef struct packed {
        logic [XLEN-1:0]      data;
        logic [ROB_IDX_W-1:0] rob;
        logic [BR_TAG_W-1:0]  tag;
    } entry_t;

    logic                   w_killValid;
    logic [BR_TAG_W-1:0]    w_killMask;
    logic [BR_TAG_W-1:0]    w_clrAnd;
    logic [SH_W-1:0]        w_shamt;
    logic [XLEN-1:0]        w_aluResult;
    logic                   w_accept;
    logic                   w_killIssue;
    logic [PIPE_STAGES-1:0] w_stgKilled;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_overflow;
    entry_t                 w_pushEntry;
    entry_t                 w_head;
    logic [SUM_W-1:0]       w_used;

    logic [PIPE_STAGES-1:0] r_stgValid;
    entry_t                 r_stg [PIPE_STAGES];
    entry_t                 r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]       r_rdPtr;
    logic [CNT_W-1:0]       r_count;

    // Squash/clear controls. Without the branch-kill feature these collapse
    // to constants so the shared datapath below reduces to plain pass-through.
`ifdef ALU_FU_BR_KILL_EN
    assign w_killValid = i_kill_valid;
    assign w_killMask  = i_kill_mask;
    assign w_clrAnd    = i_clr_valid ? ~i_clr_mask : '1;
`else
    assign w_killValid = 1'b0;
    assign w_killMask  = '0;
    assign w_clrAnd    = '1;
`endif

    // ALU datapath. The whole result is produced here in the first stage;
    // compares and branch conditions return a single flag in bit 0.
    assign w_shamt = i_issue_b[SH_W-1:0];

    always_comb begin
        w_aluResult = '0;
        case (i_issue_op)
            OP_ADD:  w_aluResult = i_issue_a + i_issue_b;
            OP_SUB:  w_aluResult = i_issue_a - i_issue_b;
            OP_SLL:  w_aluResult = i_issue_a << w_shamt;
            OP_SLT:  w_aluResult = {{(XLEN-1){1'b0}}, $signed(i_issue_a) < $signed(i_issue_b)};
            OP_SLTU: w_aluResult = {{(XLEN-1){1'b0}}, i_issue_a < i_issue_b};
            OP_XOR:  w_aluResult = i_issue_a ^ i_issue_b;
            OP_SRL:  w_aluResult = i_issue_a >> w_shamt;
            OP_SRA:  w_aluResult = $signed(i_issue_a) >>> w_shamt;
            OP_OR:   w_aluResult = i_issue_a | i_issue_b;
            OP_AND:  w_aluResult = i_issue_a & i_issue_b;
            OP_EQ:   w_aluResult = {{(XLEN-1){1'b0}}, i_issue_a == i_issue_b};
            OP_NE:   w_aluResult = {{(XLEN-1){1'b0}}, i_issue_a != i_issue_b};
            OP_GE:   w_aluResult = {{(XLEN-1){1'b0}}, $signed(i_issue_a) >= $signed(i_issue_b)};
            OP_GEU:  w_aluResult = {{(XLEN-1){1'b0}}, i_issue_a >= i_issue_b};
            default: w_aluResult = '0;
        endcase
    end

    // Credit check: every accepted op holds one credit from acceptance until
    // it is popped, so pipeline occupancy plus FIFO occupancy can never
    // exceed the FIFO depth and a push can never find the FIFO full.
    always_comb begin
        w_used = SUM_W'(r_count);
        for (int k = 0; k < PIPE_STAGES; k++) begin
            w_used = w_used + SUM_W'(r_stgValid[k]);
        end
        o_issue_ready = w_used < SUM_W'(BUF_DEPTH);
    end

    assign w_accept    = i_issue_valid && o_issue_ready;
    assign w_killIssue = w_killValid && |(i_issue_tag & w_killMask);

    // Per-stage squash flags, evaluated on the tag before any clear this
    // cycle so that kill takes precedence over clr.
    always_comb begin
        w_stgKilled = '0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            w_stgKilled[k] = w_killValid && |(r_stg[k].tag & w_killMask);
        end
    end

    // Pipeline registers. Only the valid bits are reset; the payload is
    // don't-care whenever its valid bit is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stgValid <= '0;
        end else begin
            r_stgValid[0] <= w_accept && !w_killIssue;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                r_stgValid[k] <= r_stgValid[k-1] && !w_stgKilled[k-1];
            end
        end
        r_stg[0].data <= w_aluResult;
        r_stg[0].rob  <= i_issue_rob;
        r_stg[0].tag  <= i_issue_tag & w_clrAnd;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            r_stg[k].data <= r_stg[k-1].data;
            r_stg[k].rob  <= r_stg[k-1].rob;
            r_stg[k].tag  <= r_stg[k-1].tag & w_clrAnd;
        end
    end

    assign w_push = r_stgValid[LAST] && !w_stgKilled[LAST];
    assign w_pop  = o_res_valid && i_res_taken;

    always_comb begin
        w_pushEntry     = r_stg[LAST];
        w_pushEntry.tag = r_stg[LAST].tag & w_clrAnd;
    end

`ifdef ALU_FU_BR_KILL_EN
    entry_t           w_newMem [BUF_DEPTH];
    logic [CNT_W-1:0] w_newCount;
    logic [PTR_W-1:0] w_nextRd;

    // Rebuild the FIFO contents in logical (oldest-first) order: drop the
    // popped head, drop killed entries, clear resolved tag bits, then append
    // the incoming push. A head that is both taken and killed simply leaves
    // as taken. The survivors are written back starting at the new read
    // pointer, which is how the FIFO compacts around squashed holes.
    always_comb begin : fifoCompact
        entry_t slot;
        int     n;
        slot       = '0;
        n          = 0;
        w_overflow = 1'b0;
        for (int j = 0; j < BUF_DEPTH; j++) begin
            w_newMem[j] = '0;
        end
        for (int j = 0; j < BUF_DEPTH; j++) begin
            slot = r_mem[r_rdPtr + PTR_W'(j)];
            if ((CNT_W'(j) < r_count) && !(j == 0 && w_pop) &&
                !(w_killValid && |(slot.tag & w_killMask))) begin
                slot.tag = slot.tag & w_clrAnd;
                w_newMem[PTR_W'(n)] = slot;
                n = n + 1;
            end
        end
        if (w_push) begin
            if (n < BUF_DEPTH) begin
                w_newMem[PTR_W'(n)] = w_pushEntry;
            end else begin
                w_overflow = 1'b1;
            end
            n = n + 1;
        end
        w_newCount = CNT_W'(n);
        w_nextRd   = r_rdPtr + PTR_W'(w_pop);
    end

    // FIFO state update: the whole window is rewritten every cycle from the
    // compacted image above.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            r_rdPtr <= w_nextRd;
            r_count <= w_newCount;
            for (int j = 0; j < BUF_DEPTH; j++) begin
                r_mem[w_nextRd + PTR_W'(j)] <= w_newMem[j];
            end
        end
    end
`else
    logic [PTR_W-1:0] r_wrPtr;

    assign w_overflow = w_push && !w_pop && (r_count == CNT_W'(BUF_DEPTH));

    // Plain circular FIFO. Pointers wrap naturally at the power-of-two
    // depth and the separate count tells full from empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= w_pushEntry;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
`endif

    // A push into a full FIFO means the credit accounting is broken.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!w_overflow);
        end
    end

    // Head outputs are forced to zero when empty so reset presents a clean
    // all-zero result bus without having to clear the storage array.
    assign w_head      = r_mem[r_rdPtr];
    assign o_res_valid = (r_count != '0);
    assign o_res_data  = o_res_valid ? w_head.data : '0;
    assign o_res_rob   = o_res_valid ? w_head.rob  : '0;
    assign o_res_tag   = o_res_valid ? w_head.tag  : '0;

endmodule
